// File: rtl/piezo_tone_gen.sv
// piezo_tone_gen: square-wave driver for the piezo buzzer.
// Plays note codes 1..8 (C4..C5) and a two-beep miss jingle that overrides notes.
// Optional macro CHANGE_BEEP_EN adds a short C7 chirp triggered by change_num.
module piezo_tone_gen #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned MISS_FREQ   = 200,
  parameter int unsigned MISS_CYCLES = 10000000,
  parameter int unsigned GAP_CYCLES  = 5000000,
  parameter int unsigned BEEP_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic       play_miss,
  input  logic       change_num,
  input  logic       mute,
  output logic       tone_out,
  output logic       busy,
  output logic [3:0] note_out
);

  localparam logic [23:0] HALF_C4   = 24'(CLK_FREQ / (2 * 262));
  localparam logic [23:0] HALF_D4   = 24'(CLK_FREQ / (2 * 294));
  localparam logic [23:0] HALF_E4   = 24'(CLK_FREQ / (2 * 330));
  localparam logic [23:0] HALF_F4   = 24'(CLK_FREQ / (2 * 349));
  localparam logic [23:0] HALF_G4   = 24'(CLK_FREQ / (2 * 392));
  localparam logic [23:0] HALF_A4   = 24'(CLK_FREQ / (2 * 440));
  localparam logic [23:0] HALF_B4   = 24'(CLK_FREQ / (2 * 494));
  localparam logic [23:0] HALF_C5   = 24'(CLK_FREQ / (2 * 523));
  localparam logic [23:0] HALF_MISS = 24'(CLK_FREQ / (2 * MISS_FREQ));
  localparam logic [31:0] MISS_LAST = 32'(MISS_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
`ifdef CHANGE_BEEP_EN
  localparam logic [23:0] HALF_CHIRP = 24'(CLK_FREQ / (2 * 2093));
  localparam logic [31:0] BEEP_LAST  = 32'(BEEP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_NOTE,
    ST_MISS1,
    ST_GAP,
    ST_MISS2
`ifdef CHANGE_BEEP_EN
    , ST_CHIRP
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  note_q, note_d;
  logic [23:0] div_q, div_d;
  logic [31:0] dur_q, dur_d;
  logic        tone_q, tone_d;

  logic [23:0] half_sel;
  logic [23:0] wave_div;
  logic        wave_tone;
  logic        note_valid;

`ifndef CHANGE_BEEP_EN
  logic unused_cfg;
  assign unused_cfg = change_num | (BEEP_CYCLES == 32'd0);
`endif

  assign note_valid = (note_q != 4'd0) && (note_q <= 4'd8);

  // Square-wave core: pick the half-period for the current source and advance one step.
  always_comb begin
    half_sel = HALF_MISS;
    case (state_q)
      ST_NOTE: begin
        case (note_q)
          4'd1:    half_sel = HALF_C4;
          4'd2:    half_sel = HALF_D4;
          4'd3:    half_sel = HALF_E4;
          4'd4:    half_sel = HALF_F4;
          4'd5:    half_sel = HALF_G4;
          4'd6:    half_sel = HALF_A4;
          4'd7:    half_sel = HALF_B4;
          4'd8:    half_sel = HALF_C5;
          default: half_sel = HALF_C4;
        endcase
      end
`ifdef CHANGE_BEEP_EN
      ST_CHIRP: half_sel = HALF_CHIRP;
`endif
      default:  half_sel = HALF_MISS;
    endcase
    if (div_q == half_sel - 24'd1) begin
      wave_div  = '0;
      wave_tone = ~tone_q;
    end else begin
      wave_div  = div_q + 24'd1;
      wave_tone = tone_q;
    end
  end

  // Next-state logic: note tracking, miss jingle sequencing and optional chirp.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    div_d   = div_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    case (state_q)
      ST_NOTE: begin
        if (play_miss) begin
          state_d = ST_MISS1;
          div_d   = '0;
          dur_d   = '0;
          tone_d  = 1'b0;
`ifdef CHANGE_BEEP_EN
        end else if (change_num) begin
          state_d = ST_CHIRP;
          div_d   = '0;
          dur_d   = '0;
          tone_d  = 1'b0;
`endif
        end else if (note_in != note_q) begin
          note_d = note_in;
          div_d  = '0;
          tone_d = 1'b0;
        end else if (note_valid) begin
          div_d  = wave_div;
          tone_d = wave_tone;
        end else begin
          div_d  = '0;
          tone_d = 1'b0;
        end
      end
      ST_MISS1, ST_MISS2: begin
        // Beep end takes priority over a toggle landing on the same cycle.
        if (dur_q == MISS_LAST) begin
          state_d = (state_q == ST_MISS1) ? ST_GAP : ST_NOTE;
          if (state_q == ST_MISS2) note_d = '0;
          div_d  = '0;
          dur_d  = '0;
          tone_d = 1'b0;
        end else begin
          dur_d  = dur_q + 32'd1;
          div_d  = wave_div;
          tone_d = wave_tone;
        end
      end
      ST_GAP: begin
        div_d  = '0;
        tone_d = 1'b0;
        if (dur_q == GAP_LAST) begin
          state_d = ST_MISS2;
          dur_d   = '0;
        end else begin
          dur_d = dur_q + 32'd1;
        end
      end
`ifdef CHANGE_BEEP_EN
      ST_CHIRP: begin
        if (play_miss) begin
          state_d = ST_MISS1;
          div_d   = '0;
          dur_d   = '0;
          tone_d  = 1'b0;
        end else if (dur_q == BEEP_LAST) begin
          state_d = ST_NOTE;
          note_d  = '0;
          div_d   = '0;
          dur_d   = '0;
          tone_d  = 1'b0;
        end else begin
          dur_d  = dur_q + 32'd1;
          div_d  = wave_div;
          tone_d = wave_tone;
        end
      end
`endif
      default: begin
        state_d = ST_NOTE;
        note_d  = '0;
        div_d   = '0;
        dur_d   = '0;
        tone_d  = 1'b0;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_NOTE;
      note_q  <= '0;
      div_q   <= '0;
      dur_q   <= '0;
      tone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      div_q   <= div_d;
      dur_q   <= dur_d;
      tone_q  <= tone_d;
    end
  end

  assign busy     = (state_q != ST_NOTE);
  assign note_out = (state_q == ST_NOTE && note_valid) ? note_q : '0;
  assign tone_out = tone_q & ~mute;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Testbench for piezo_tone_gen: directed vector table, multi-cycle sequences
// and random stimulus, all compared against an arithmetic reference model.
module tb_piezo_tone_gen;

  localparam int unsigned CLK_FREQ    = 1000000;
  localparam int unsigned MISS_FREQ   = 200;
  localparam int unsigned MISS_CYCLES = 6000;
  localparam int unsigned GAP_CYCLES  = 3000;
  localparam int unsigned BEEP_CYCLES = 2000;
  localparam int          JINGLE_LEN  = 2 * MISS_CYCLES + GAP_CYCLES;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] note_in = '0;
  logic       play_miss = 1'b0;
  logic       change_num = 1'b0;
  logic       mute = 1'b0;
  logic       tone_out;
  logic       busy;
  logic [3:0] note_out;

  int errors = 0;
  int checks = 0;

  piezo_tone_gen #(
    .CLK_FREQ(CLK_FREQ),
    .MISS_FREQ(MISS_FREQ),
    .MISS_CYCLES(MISS_CYCLES),
    .GAP_CYCLES(GAP_CYCLES),
    .BEEP_CYCLES(BEEP_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .note_in(note_in),
    .play_miss(play_miss),
    .change_num(change_num),
    .mute(mute),
    .tone_out(tone_out),
    .busy(busy),
    .note_out(note_out)
  );

  always #5 clk = ~clk;

  // Reference model: mode (0 note, 1 jingle, 2 chirp), current note, edges since segment start.
  int freq_tab [9] = '{0, 262, 294, 330, 349, 392, 440, 494, 523};
  int m_mode = 0;
  int m_note = 0;
  int m_n    = 0;

  function automatic int half_of(input int f);
    return int'(CLK_FREQ) / (2 * f);
  endfunction

  function automatic logic sq(input int n, input int h);
    return ((n / h) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_mode = 0; m_note = 0; m_n = 0;
    end else if (m_mode == 0) begin
      if (play_miss) begin
        m_mode = 1; m_n = 0;
`ifdef CHANGE_BEEP_EN
      end else if (change_num) begin
        m_mode = 2; m_n = 0;
`endif
      end else if (int'(note_in) != m_note) begin
        m_note = int'(note_in); m_n = 0;
      end else begin
        m_n++;
      end
    end else if (m_mode == 1) begin
      m_n++;
      if (m_n == JINGLE_LEN) begin m_mode = 0; m_note = 0; m_n = 0; end
    end else begin
      if (play_miss) begin
        m_mode = 1; m_n = 0;
      end else begin
        m_n++;
        if (m_n == int'(BEEP_CYCLES)) begin m_mode = 0; m_note = 0; m_n = 0; end
      end
    end
  end

  task automatic model_outputs(output logic t, output logic b, output logic [3:0] n);
    logic ti;
    ti = 1'b0; b = 1'b0; n = '0;
    if (m_mode == 0) begin
      if (m_note >= 1 && m_note <= 8) begin
        ti = sq(m_n, half_of(freq_tab[m_note]));
        n  = 4'(m_note);
      end
    end else if (m_mode == 1) begin
      b = 1'b1;
      if (m_n < int'(MISS_CYCLES)) ti = sq(m_n, half_of(int'(MISS_FREQ)));
      else if (m_n >= int'(MISS_CYCLES + GAP_CYCLES))
        ti = sq(m_n - int'(MISS_CYCLES + GAP_CYCLES), half_of(int'(MISS_FREQ)));
    end else begin
      b  = 1'b1;
      ti = sq(m_n, half_of(2093));
    end
    t = ti & ~mute;
  endtask

  // One clock cycle, then compare every output against the model.
  task automatic tick();
    logic et, eb;
    logic [3:0] en;
    @(posedge clk);
    @(negedge clk);
    model_outputs(et, eb, en);
    checks++;
    if ({tone_out, busy, note_out} !== {et, eb, en}) begin
      errors++;
      $display("FAIL model_cycle t=%0t got tone=%b busy=%b note=%0d expected tone=%b busy=%b note=%0d",
               $time, tone_out, busy, note_out, et, eb, en);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tone(input logic lvl, input int limit, output int cnt);
    cnt = 0;
    while (cnt < limit) begin
      tick();
      cnt++;
      if (tone_out === lvl) break;
    end
  endtask

  task automatic wait_idle(input int limit, output int cnt);
    cnt = 0;
    while (cnt < limit) begin
      tick();
      cnt++;
      if (busy === 1'b0) break;
    end
  endtask

  typedef struct {
    logic [3:0] note;
    logic       miss;
    logic       mute;
    int         cyc;
    logic       tone;
    logic       busy;
    logic [3:0] nout;
  } vec_t;

  vec_t vecs [21];

  initial begin
    int c;
    vecs[0]  = '{4'd0, 1'b0, 1'b0, 1000, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{4'd6, 1'b0, 1'b0, 1,    1'b0, 1'b0, 4'd6};
    vecs[2]  = '{4'd6, 1'b0, 1'b0, 1135, 1'b0, 1'b0, 4'd6};
    vecs[3]  = '{4'd6, 1'b0, 1'b0, 1,    1'b1, 1'b0, 4'd6};
    vecs[4]  = '{4'd6, 1'b0, 1'b0, 2271, 1'b0, 1'b0, 4'd6};
    vecs[5]  = '{4'd6, 1'b0, 1'b0, 1,    1'b1, 1'b0, 4'd6};
    vecs[6]  = '{4'd6, 1'b0, 1'b1, 500,  1'b0, 1'b0, 4'd6};
    vecs[7]  = '{4'd6, 1'b0, 1'b0, 1,    1'b1, 1'b0, 4'd6};
    vecs[8]  = '{4'd1, 1'b0, 1'b0, 1,    1'b0, 1'b0, 4'd1};
    vecs[9]  = '{4'd1, 1'b0, 1'b0, 1907, 1'b0, 1'b0, 4'd1};
    vecs[10] = '{4'd1, 1'b0, 1'b0, 1,    1'b1, 1'b0, 4'd1};
    vecs[11] = '{4'd3, 1'b1, 1'b0, 1,    1'b0, 1'b1, 4'd0};
    vecs[12] = '{4'd3, 1'b0, 1'b0, 2499, 1'b0, 1'b1, 4'd0};
    vecs[13] = '{4'd3, 1'b0, 1'b0, 1,    1'b1, 1'b1, 4'd0};
    vecs[14] = '{4'd5, 1'b1, 1'b0, 3500, 1'b0, 1'b1, 4'd0};
    vecs[15] = '{4'd3, 1'b0, 1'b0, 3000, 1'b0, 1'b1, 4'd0};
    vecs[16] = '{4'd3, 1'b0, 1'b0, 2500, 1'b1, 1'b1, 4'd0};
    vecs[17] = '{4'd3, 1'b0, 1'b0, 3499, 1'b0, 1'b1, 4'd0};
    vecs[18] = '{4'd3, 1'b0, 1'b0, 1,    1'b0, 1'b0, 4'd0};
    vecs[19] = '{4'd3, 1'b0, 1'b0, 1,    1'b0, 1'b0, 4'd3};
    vecs[20] = '{4'd3, 1'b0, 1'b0, 1515, 1'b1, 1'b0, 4'd3};

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) tick();
    check("reset_tone", int'(tone_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_note", int'(note_out), 0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      note_in   = vecs[i].note;
      mute      = vecs[i].mute;
      play_miss = vecs[i].miss;
      tick();
      play_miss = 1'b0;
      for (int k = 1; k < vecs[i].cyc; k++) tick();
      check($sformatf("vec%0d_tone", i), int'(tone_out), int'(vecs[i].tone));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      check($sformatf("vec%0d_note", i), int'(note_out), int'(vecs[i].nout));
    end

    // Reset part-way through a jingle, then C5.
    note_in = 4'd0;
    play_miss = 1'b1; tick(); play_miss = 1'b0;
    for (int k = 0; k < 7499; k++) tick();
    reset = 1'b0; note_in = 4'd8;
    tick();
    check("midjingle_reset_tone", int'(tone_out), 0);
    check("midjingle_reset_busy", int'(busy), 0);
    reset = 1'b1;
    tick();
    check("c5_note_out", int'(note_out), 8);
    wait_tone(1'b1, 2000, c); check("c5_first_rise", c, 956);
    wait_tone(1'b0, 2000, c); check("c5_high_time", c, 956);
    wait_tone(1'b1, 2000, c); check("c5_low_time", c, 956);

    // Mute during G4 keeps the internal phase running.
    note_in = 4'd5; tick();
    mute = 1'b1;
    for (int k = 0; k < 2999; k++) tick();
    check("mute_forces_low", int'(tone_out), 0);
    mute = 1'b0;
    wait_tone(1'b1, 3000, c); check("unmute_phase_rise", c, 826);
    wait_tone(1'b0, 3000, c); check("g4_high_time", c, 1275);

    // change_num handling.
    note_in = 4'd0; tick();
    change_num = 1'b1; tick(); change_num = 1'b0;
`ifdef CHANGE_BEEP_EN
    check("chirp_busy", int'(busy), 1);
    wait_tone(1'b1, 3000, c); check("chirp_first_rise", c, 238);
    wait_idle(3000, c);        check("chirp_remaining", c, int'(BEEP_CYCLES) - 238);
    change_num = 1'b1; tick(); change_num = 1'b0;
    for (int k = 0; k < 99; k++) tick();
    play_miss = 1'b1; tick(); play_miss = 1'b0;
    for (int k = 0; k < 2500; k++) tick();
    check("chirp_abort_miss_tone", int'(tone_out), 1);
    check("chirp_abort_busy", int'(busy), 1);
    reset = 1'b0; tick(); reset = 1'b1; tick();
    play_miss = 1'b1; change_num = 1'b1; tick();
    play_miss = 1'b0; change_num = 1'b0;
    for (int k = 0; k < 2500; k++) tick();
    check("miss_beats_change_tone", int'(tone_out), 1);
    reset = 1'b0; tick(); reset = 1'b1; tick();
`else
    check("change_ignored_busy", int'(busy), 0);
    for (int k = 0; k < 100; k++) tick();
    check("change_ignored_later", int'(busy), 0);
`endif

    // Random stimulus against the model.
    for (int k = 0; k < 6000; k++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 5) note_in = 4'($urandom_range(0, 15));
      if (r >= 5 && r < 8) mute = ~mute;
      play_miss  = (r == 8);
      change_num = (r == 9);
      reset      = (r != 10);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
